// File: rtl/mdu_pkg.sv
// Shared types for the RV32M multiply/divide unit: FSM states, funct3 op codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Values match the RV32M funct3 field so the decoder can pass it straight through.
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, try to subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller sequences iterations.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic         in_bit,
   input  logic [W-1:0] divisor,
   output logic         q_bit,
   output logic [W-1:0] rem_out
);

   logic [W:0] shifted;
   logic [W:0] trial;

   // rem_in < divisor holds on entry, so the shifted value fits W+1 bits and
   // the top bit of the trial difference is a clean borrow flag.
   always_comb begin
      shifted = {rem_in, in_bit};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[W];
      rem_out = q_bit ? trial[W-1:0] : shifted[W-1:0];
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide beside the execute-stage ALU; stalls the pipe while busy.
// Latency: done in cycle 34 after the start cycle; divide-by-zero/overflow done in cycle 1.
// Backpressure: start accepted only in IDLE; stall held until the result is ready.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   input  logic                  flush,
   output logic                  busy,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   state_t               state;
   op_t                  op_q;
   logic                 neg_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic [W-1:0]         mag_d;   // multiplicand for multiply, divisor for divide
   logic [2*W-1:0]       acc;     // {high product | remainder, low product | quotient}

   logic         signed_a, signed_b, sign_a, sign_b;
   logic [W-1:0] abs_a, abs_b;
   logic         is_div, is_rem, div_zero, ovf, neg_start;
   logic [W-1:0] special_res;
   logic [W:0]   msum;
   logic [2*W-1:0] acc_mul_next, acc_div_next, prod_fix;
   logic         q_bit;
   logic [W-1:0] rem_out;
   logic [W-1:0] div_field, fix_res;

   // Decode signedness and special cases from the live inputs in the start cycle.
   always_comb begin
      signed_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      signed_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      sign_a    = signed_a & op_a[W-1];
      sign_b    = signed_b & op_b[W-1];
      abs_a     = sign_a ? -op_a : op_a;
      abs_b     = sign_b ? -op_b : op_b;
      is_div    = op[2];
      is_rem    = op[2] & op[1];
      div_zero  = is_div && (op_b == '0);
      ovf       = ((op == OP_DIV) || (op == OP_REM)) && (op_a == MIN_NEG) && (op_b == '1);
      neg_start = is_rem ? sign_a : (sign_a ^ sign_b);
      special_res = '0;
      if (div_zero)
         special_res = is_rem ? op_a : '1;
      else if (ovf)
         special_res = is_rem ? '0 : MIN_NEG;
   end

   // Shift-add multiply step: multiplier sits in the low half and drains out the bottom.
   always_comb begin
      msum         = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_d} : '0);
      acc_mul_next = {msum, acc[W-1:1]};
   end

   div_step #(.W(W)) u_div_step (
      .rem_in  (acc[2*W-1:W]),
      .in_bit  (acc[W-1]),
      .divisor (mag_d),
      .q_bit   (q_bit),
      .rem_out (rem_out)
   );

   assign acc_div_next = {rem_out, acc[W-2:0], q_bit};

   // Sign correction and field selection for the FIX cycle.
   always_comb begin
      prod_fix  = neg_q ? -acc : acc;
      div_field = op_q[1] ? acc[2*W-1:W] : acc[W-1:0];
      if (op_q[2])
         fix_res = neg_q ? -div_field : div_field;
      else if (op_q == OP_MUL)
         fix_res = prod_fix[W-1:0];
      else
         fix_res = prod_fix[2*W-1:W];
   end

   // Control FSM and datapath registers; flush aborts without touching result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= OP_MUL;
         neg_q  <= 1'b0;
         cnt    <= '0;
         mag_d  <= '0;
         acc    <= '0;
         result <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op_t'(op);
                  neg_q <= neg_start;
                  cnt   <= '0;
                  if (div_zero || ovf) begin
                     result <= special_res;
                     state  <= DONE;
                  end else begin
                     mag_d <= is_div ? abs_b : abs_a;
                     acc   <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= op_q[2] ? acc_div_next : acc_mul_next;
               cnt <= cnt + CNT_WIDTH'(1);
               if (cnt == '1)
                  state <= FIX;
            end
            FIX: begin
               result <= fix_res;
               state  <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign stall = (start && (state == IDLE)) || (busy && !done);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected results queued at start, popped at done.
// Latency: checks done cycle, stall window, and abort/ignore behaviour.
// Backpressure: waits on done are bounded by a cycle budget.
module tb_mul_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  op;
   logic [31:0] op_a, op_b;
   logic        busy, stall, done;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_exp = 32'd0;

   always #5 clk = ~clk;

   mul_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Launch one op in the cycle after the call, optionally re-assert start at
   // cycle restart_cyc with other operands, and verify latency, stall and result.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input int lat,
                         input int restart_cyc);
      int done_cyc;
      int stall_bad;
      logic [31:0] expv;
      done_cyc  = -1;
      stall_bad = 0;
      @(negedge clk);
      check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
      op = o; op_a = a; op_b = b; start = 1'b1;
      exp_q.push_back(e);
      last_exp = e;
      #1;
      if (!stall) stall_bad++;
      for (int k = 1; k <= 60 && done_cyc < 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         op    = 3'($urandom);
         op_a  = $urandom;
         op_b  = $urandom;
         if (k == restart_cyc) begin
            start = 1'b1; op = OP_MUL; op_a = 32'd3; op_b = 32'd3;
         end
         #1;
         if (done) done_cyc = k;
         else if (!stall) stall_bad++;
         if (done && k == restart_cyc) begin
            @(posedge clk);
            #1;
         end
      end
      start = 1'b0;
      check({tag, ".lat"}, 32'(done_cyc), 32'(lat));
      expv = exp_q.pop_front();
      if (done_cyc >= 0)
         check({tag, ".result"}, result, expv);
      check({tag, ".stall"}, 32'(stall_bad), 32'd0);
   endtask

   // Start DIVU 100/7 then abort it at cycle 10 with flush or reset.
   task automatic abort_op(input string tag, input bit use_rst);
      int seen;
      seen = 0;
      @(negedge clk);
      check({tag, ".idle"}, {31'd0, busy}, 32'd0);
      op = OP_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         op_a  = $urandom;
         if (k == 10) begin
            if (use_rst) rst = 1'b1;
            else         flush = 1'b1;
         end
      end
      @(negedge clk);
      rst = 1'b0;
      flush = 1'b0;
      #1;
      if (use_rst) last_exp = 32'd0;
      check({tag, ".busy"}, {31'd0, busy}, 32'd0);
      check({tag, ".result"}, result, last_exp);
      repeat (40) begin
         @(negedge clk);
         #1;
         if (done) seen++;
      end
      check({tag, ".nodone"}, 32'(seen), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      op = 3'd0; op_a = 32'd0; op_b = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset.ctrl", {29'd0, busy, done, stall}, 32'd0);
      check("reset.result", result, 32'd0);

      run_op("mul",       OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, -1);
      run_op("mulh",      OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, -1);
      run_op("mulhu",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, -1);
      run_op("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, -1);
      run_op("div",       OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, -1);
      run_op("rem",       OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, -1);
      run_op("div_negb",  OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, -1);
      run_op("rem_negb",  OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34, -1);
      run_op("divu",      OP_DIVU,   32'd100,        32'd7,         32'd14,        34, -1);
      run_op("remu",      OP_REMU,   32'd100,        32'd7,         32'd2,         34, -1);
      run_op("divu_z",    OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,  -1);
      run_op("remu_z",    OP_REMU,   32'd5,          32'd0,         32'd5,         1,  -1);
      run_op("rem_z",     OP_REM,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 1,  -1);
      run_op("div_ovf",   OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  -1);
      run_op("rem_ovf",   OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  -1);
      run_op("divu_noovf",OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34, -1);

      // start re-asserted mid-CALC, then again in the DONE cycle: both ignored
      run_op("divu_restart", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 5);
      run_op("remu_donest",  OP_REMU, 32'd100, 32'd7, 32'd2,  34, 34);

      abort_op("flush", 1'b0);

      // flush and start together in IDLE: nothing accepted
      @(negedge clk);
      op = OP_DIVU; op_a = 32'd9; op_b = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_start.busy", {31'd0, busy}, 32'd0);
      check("flush_start.result", result, last_exp);

      abort_op("rstabort", 1'b1);
      run_op("divu_after", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
- Takes the same two operands the ALU sees: rs1 value, and the post-ALUsrc-mux operand.
- Its result joins the ALU result at the execute-stage result mux ahead of the EX/MEM register.
- Raises a stall request to the hazard logic while an operation is in flight, so the pipeline freezes until the result is ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2**CNT_WIDTH == DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  DATA_WIDTH  rs1 operand (dividend / multiplicand).
- op_b  input  DATA_WIDTH  rs2 operand (divisor / multiplier).
- flush  input  1  abort the in-flight operation (branch mispredict / trap).
- busy  output  1  high in every non-IDLE state.
- stall  output  1  start & IDLE, or busy & ~done.
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  DATA_WIDTH  final result; held until the next accepted start.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0; counter and internal registers cleared. Reset mid-operation discards the operation and produces no done.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE. Special cases go IDLE -> DONE directly.
- IDLE, start=1, normal case:
  - Latch op.
  - Latch |op_a| and |op_b| according to signedness: MULH/DIV/REM both operands signed; MULHSU op_a only; MULHU/DIVU/REMU/MUL unsigned.
  - Record the result sign, clear the counter, go to CALC.
- CALC, multiply: 32 cycles of shift-add on a 64-bit product register.
- CALC, divide: 32 cycles of restoring shift-subtract, producing quotient and remainder.
- Counter increments each CALC cycle; wraps at 31 -> leave for FIX.
- FIX, one cycle:
  - Negate if required. Product sign = sign_a ^ sign_b (signed-operand positions only). Quotient sign = sign_a ^ sign_b. Remainder sign = sign_a.
  - Select the field: MUL low 32 bits; MULH* high 32 bits; DIV* quotient; REM* remainder.
  - Register result, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled in cycle 0; done high in cycle 34.
- Special cases, decided in IDLE; go straight to DONE, so done is high in cycle 1:
  - Divide by zero (op_b==0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- Handshake:
  - start outside IDLE is ignored.
  - start in the DONE cycle is ignored; upstream re-presents it the following cycle.
  - Upstream holds op/op_a/op_b stable only in the start cycle; all needed values are latched.
- flush: in any state, return to IDLE on the next edge with no done pulse; result keeps its previous value. flush and start together in IDLE: flush wins, nothing is accepted.
- Priority: rst > flush > start.
- All arithmetic is unsigned on magnitudes with explicit widths; no reliance on $signed extension inside the loop.

Decomposition:
- Package mdu_pkg: state enum (IDLE, CALC, FIX, DONE), op enum matching the funct3 encodings, DATA_WIDTH default constant.
- Sub-module div_step: one combinational restoring-division iteration (remainder in, divisor, quotient bit out, next remainder). Instantiated once; the multiply step stays inline.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly in cycle 34; stall high in cycles 0-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with done in cycle 1.
- start DIVU 100/7, flush at cycle 10 -> IDLE at cycle 11, no done, result unchanged. Same sequence with rst instead -> result 0, no done.
- start re-asserted during CALC with different operands -> ignored; original result delivered at cycle 34. Back-to-back start in the cycle after done -> accepted.
